// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    // Frame parser states; every state other than DONE keeps the core in reset.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        LOAD   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_t;

    // Number of header bytes (little-endian 16-bit word count) ahead of the payload.
    localparam int unsigned HDR_LEN = 2;

    // Assemble the 16-bit word count from its two header bytes.
    function automatic logic [15:0] form_count(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit little-endian words and keeps a running XOR of every byte.
// Latency: word_vld_o/word_o are combinational with the 4th byte strobe; checksum updates on the next edge.
// Backpressure: none; every strobed byte is consumed.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        word_vld_o,
    output logic [31:0] word_o,
    output logic [7:0]  csum_o
);

    logic [1:0]  idx_q;
    logic [23:0] lanes_q;
    logic [7:0]  acc_q;

    // Byte index, the three low lanes of the word in progress, and the XOR accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= 2'd0;
            lanes_q <= 24'd0;
            acc_q   <= 8'd0;
        end else if (clear_i) begin
            idx_q   <= 2'd0;
            lanes_q <= 24'd0;
            acc_q   <= 8'd0;
        end else if (byte_vld_i) begin
            idx_q <= idx_q + 2'd1;
            acc_q <= acc_q ^ byte_i;
            case (idx_q)
                2'd0:    lanes_q[7:0]   <= byte_i;
                2'd1:    lanes_q[15:8]  <= byte_i;
                2'd2:    lanes_q[23:16] <= byte_i;
                default: lanes_q        <= lanes_q;
            endcase
        end
    end

    // The top lane never needs storage: the word is complete the moment it arrives.
    always_comb begin
        word_vld_o = byte_vld_i && (idx_q == 2'd3);
        word_o     = {byte_i, lanes_q};
        csum_o     = acc_q;
    end

endmodule

// File: rtl/inst_loader.sv
// Frame-driven loader that writes received words into instruction RAM and releases the core on a good checksum.
// Latency: RAM write pulse one cycle after the byte completing a word; state changes one cycle after each byte.
// Backpressure: none; bytes are strobes, and bytes arriving in DONE/ERROR are dropped.
module inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH          = 128,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk_100mhz,
    input  logic              rst_in,
    input  logic              byte_valid_in,
    input  logic [7:0]        byte_in,
    input  logic              rearm_in,
    output logic              inst_we_out,
    output logic [ADDR_W-1:0] inst_addr_out,
    output logic [31:0]       inst_data_out,
    output logic              cpu_rst_out,
    output logic              done_out,
    output logic              error_out,
    output logic [15:0]       words_loaded_out
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              pk_clear;
    logic              pk_vld;
    logic              pk_word_vld;
    logic [31:0]       pk_word;
    logic [7:0]        pk_csum;
    logic [15:0]       n_rx;
    logic [ADDR_W+15:0] wcnt_ext;

    // Packer restarts on every count_hi byte and only sees bytes while loading payload.
    assign pk_clear = (state_q == HDR_HI) && byte_valid_in;
    assign pk_vld   = (state_q == LOAD) && byte_valid_in;

    byte_packer u_packer (
        .clk_i      (clk_100mhz),
        .rst_i      (rst_in),
        .clear_i    (pk_clear),
        .byte_vld_i (pk_vld),
        .byte_i     (byte_in),
        .word_vld_o (pk_word_vld),
        .word_o     (pk_word),
        .csum_o     (pk_csum)
    );

    assign n_rx     = form_count(cnt_lo_q, byte_in);
    assign wcnt_ext = {{ADDR_W{1'b0}}, wcnt_q};

    // Frame FSM, write-port staging and the inter-byte idle timeout.
    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        tmo_d    = tmo_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (byte_valid_in) begin
                    cnt_lo_d = byte_in;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (byte_valid_in) begin
                    n_d = n_rx;
                    if (n_rx > DEPTH16) begin
                        state_d = ERROR;
                    end else if (n_rx == 16'd0) begin
                        wcnt_d  = 16'd0;
                        state_d = CHECK;
                    end else begin
                        wcnt_d  = 16'd0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // Counters advance in the write cycle itself; the RAM address is the pre-increment count.
                if (pk_word_vld) begin
                    we_d   = 1'b1;
                    addr_d = wcnt_ext[ADDR_W-1:0];
                    data_d = pk_word;
                    wcnt_d = wcnt_q + 16'd1;
                    if (wcnt_q + 16'd1 == n_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byte_valid_in) begin
                    state_d = (byte_in == pk_csum) ? DONE : ERROR;
                end
            end
            DONE, ERROR: begin
                tmo_d = '0;
                if (rearm_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A byte always restarts the idle count; timeout only fires on a byte-free cycle.
        if ((state_q == HDR_HI) || (state_q == LOAD) || (state_q == CHECK)) begin
            if (byte_valid_in) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = ERROR;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // State and datapath registers; reset lands directly on the hold-in-reset values.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_lo_q <= 8'd0;
            n_q      <= 16'd0;
            wcnt_q   <= 16'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= 32'd0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tmo_q    <= tmo_d;
        end
    end

    // Status outputs decode straight from the state register so reset takes effect at once.
    always_comb begin
        inst_we_out      = we_q;
        inst_addr_out    = addr_q;
        inst_data_out    = data_q;
        words_loaded_out = wcnt_q;
        cpu_rst_out      = (state_q != DONE);
        done_out         = (state_q == DONE);
        error_out        = (state_q == ERROR);
    end

endmodule
